// File: rtl/sram_like_port_arbiter_pkg.sv
// Shared definitions for the SRAM-like port arbiter: FSM state codes,
// owner codes, transfer size codes and the grant-priority helper.
// Optional feature macro used by the arbiter: ARB_STARVE_GUARD_EN.
package sram_like_port_arbiter_pkg;

   // Arbiter FSM state encodings
   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_ADDR = 2'd1;
   localparam logic [1:0] ARB_DATA = 2'd2;

   // Owner of the in-flight transaction
   localparam logic ARB_OWN_INST = 1'b0;
   localparam logic ARB_OWN_DATA = 1'b1;

   // Bus transfer size codes
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Data wins the port unless the starvation guard is forcing a fetch
   // and a fetch is actually waiting.
   function automatic logic pick_data(input logic data_req,
                                      input logic inst_req,
                                      input logic force_inst);
      return data_req & ~(force_inst & inst_req);
   endfunction

endpackage

// File: rtl/sram_like_port_arbiter_arb_req_latch.sv
// Registered request mux: captures owner and request fields of the granted
// requester so the bus sees stable values for the whole address phase.
module arb_req_latch
   import sram_like_port_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          sel_data,
   input  logic [AW-1:0] inst_addr,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic          owner,
   output logic          wr,
   output logic [1:0]    size,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata
);

   logic          owner_r;
   logic          wr_r;
   logic [1:0]    size_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r;

   // Load the winning requester's fields at grant, hold them otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_r <= ARB_OWN_INST;
         wr_r    <= 1'b0;
         size_r  <= 2'd0;
         addr_r  <= {AW{1'b0}};
         wdata_r <= {DW{1'b0}};
      end else if (load) begin
         if (sel_data) begin
            owner_r <= ARB_OWN_DATA;
            wr_r    <= data_wr;
            size_r  <= data_size;
            addr_r  <= data_addr;
            wdata_r <= data_wdata;
         end else begin
            // fetches are always word reads
            owner_r <= ARB_OWN_INST;
            wr_r    <= 1'b0;
            size_r  <= SZ_W;
            addr_r  <= inst_addr;
            wdata_r <= {DW{1'b0}};
         end
      end else begin
         owner_r <= owner_r;
         wr_r    <= wr_r;
         size_r  <= size_r;
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
      end
   end

   assign owner = owner_r;
   assign wr    = wr_r;
   assign size  = size_r;
   assign addr  = addr_r;
   assign wdata = wdata_r;

endmodule

// File: rtl/sram_like_port_arbiter.sv
// Shares one SRAM-like memory port between the IF fetch requester and the
// MEM load/store requester. One transaction outstanding at most; data has
// priority. Optional macro ARB_STARVE_GUARD_EN forces a fetch grant after
// MAX_DATA_STREAK contested data grants in a row.
module sram_like_port_arbiter
   import sram_like_port_arbiter_pkg::*;
#(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          inst_req,
   input  logic [AW-1:0] inst_addr,
   output logic          inst_rvalid,
   output logic [DW-1:0] inst_rdata,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic          data_rvalid,
   output logic [DW-1:0] data_rdata,
   output logic          stallreq_if,
   output logic          stallreq_mem,
   output logic          bus_req,
   output logic          bus_wr,
   output logic [1:0]    bus_size,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_addr_ok,
   input  logic          bus_data_ok,
   input  logic [DW-1:0] bus_rdata
);

   logic [1:0]    state_r;
   logic [1:0]    state_nx_s;
   logic          discard_r;
   logic [DW-1:0] inst_hold_r;
   logic [DW-1:0] data_hold_r;

   logic          own_s;
   logic          wr_s;
   logic [1:0]    size_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] wdata_s;

   logic          in_addr_s;
   logic          in_data_s;
   logic          done_s;
   logic          inst_done_s;
   logic          data_done_s;
   logic          grant_s;
   logic          grant_data_s;
   logic          force_inst_s;
   logic [DW-1:0] data_ret_s;

   assign in_addr_s    = (state_r == ARB_ADDR);
   assign in_data_s    = (state_r == ARB_DATA);
   // completion: data_ok in DATA, or both handshakes in the same ADDR cycle
   assign done_s       = (in_addr_s & bus_addr_ok & bus_data_ok) | (in_data_s & bus_data_ok);
   assign inst_done_s  = done_s & (own_s == ARB_OWN_INST);
   assign data_done_s  = done_s & (own_s == ARB_OWN_DATA);
   assign grant_s      = (state_r == ARB_IDLE) & ~flush & (inst_req | data_req);
   assign grant_data_s = pick_data(data_req, inst_req, force_inst_s);

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   logic [SW-1:0] streak_r;

   assign force_inst_s = (streak_r == STREAK_MAX);

   // Count contested data grants in a row; any fetch grant clears the run
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak_r <= {SW{1'b0}};
      end else if (grant_s) begin
         if (!grant_data_s) begin
            streak_r <= {SW{1'b0}};
         end else if (inst_req) begin
            if (streak_r != STREAK_MAX) begin
               streak_r <= streak_r + SW'(1);
            end else begin
               streak_r <= streak_r;
            end
         end else begin
            streak_r <= {SW{1'b0}};
         end
      end else begin
         streak_r <= streak_r;
      end
   end
`else
   assign force_inst_s = 1'b0;
`endif

   arb_req_latch #(
      .AW (AW),
      .DW (DW)
   ) u_req_latch (
      .clk        (clk),
      .rst        (rst),
      .load       (grant_s),
      .sel_data   (grant_data_s),
      .inst_addr  (inst_addr),
      .data_wr    (data_wr),
      .data_size  (data_size),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .owner      (own_s),
      .wr         (wr_s),
      .size       (size_s),
      .addr       (addr_s),
      .wdata      (wdata_s)
   );

   // Next-state logic of the IDLE -> ADDR -> DATA handshake sequence
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ARB_IDLE: begin
            if (grant_s) state_nx_s = ARB_ADDR;
            else         state_nx_s = ARB_IDLE;
         end
         ARB_ADDR: begin
            if (done_s)           state_nx_s = ARB_IDLE;
            else if (bus_addr_ok) state_nx_s = ARB_DATA;
            else                  state_nx_s = ARB_ADDR;
         end
         ARB_DATA: begin
            if (bus_data_ok) state_nx_s = ARB_IDLE;
            else             state_nx_s = ARB_DATA;
         end
         default: state_nx_s = ARB_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ARB_IDLE;
      else      state_r <= state_nx_s;
   end

   // A flushed fetch still finishes on the bus but its response is dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         discard_r <= 1'b0;
      end else if (done_s) begin
         discard_r <= 1'b0;
      end else if (flush & (in_addr_s | in_data_s) & (own_s == ARB_OWN_INST)) begin
         discard_r <= 1'b1;
      end else begin
         discard_r <= discard_r;
      end
   end

   assign data_ret_s = wr_s ? {DW{1'b0}} : bus_rdata;

   // Holding registers keep the last returned word after the valid pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_hold_r <= {DW{1'b0}};
         data_hold_r <= {DW{1'b0}};
      end else begin
         if (inst_rvalid) inst_hold_r <= bus_rdata;
         else             inst_hold_r <= inst_hold_r;
         if (data_done_s) data_hold_r <= data_ret_s;
         else             data_hold_r <= data_hold_r;
      end
   end

   assign bus_req     = in_addr_s;
   assign bus_wr      = wr_s;
   assign bus_size    = size_s;
   assign bus_addr    = addr_s;
   assign bus_wdata   = wdata_s;

   assign inst_rvalid = inst_done_s & ~discard_r & ~flush;
   assign inst_rdata  = inst_rvalid ? bus_rdata : inst_hold_r;
   assign data_rvalid = data_done_s;
   assign data_rdata  = data_done_s ? data_ret_s : data_hold_r;

   // stalls are held low while reset is asserted
   assign stallreq_mem = rst & data_req & ~data_done_s;
   assign stallreq_if  = rst & ((inst_req & ~inst_done_s) | data_req);

endmodule

// File: tb/tb_sram_like_port_arbiter.sv
// Self-checking bench for sram_like_port_arbiter: directed requester
// stimulus, a programmable-latency bus responder, a transaction-level
// reference model compared every cycle, and literal checks per scenario.
module tb_sram_like_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          flush;
   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic          inst_rvalid;
   logic [DW-1:0] inst_rdata;
   logic          data_req;
   logic          data_wr;
   logic [1:0]    data_size;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_wdata;
   logic          data_rvalid;
   logic [DW-1:0] data_rdata;
   logic          stallreq_if;
   logic          stallreq_mem;
   logic          bus_req;
   logic          bus_wr;
   logic [1:0]    bus_size;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_addr_ok;
   logic          bus_data_ok;
   logic [DW-1:0] bus_rdata;

   sram_like_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- bus responder ----------------
   int          addr_wait = 0;
   int          data_wait = 1;
   logic [31:0] slave_rdata = 32'h0;
   int          s_cnt = 0;
   bit          s_phase = 1'b0;

   assign bus_rdata = bus_data_ok ? slave_rdata : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (!rst) begin
         s_phase = 1'b0;
         s_cnt   = 0;
      end else if (!s_phase) begin
         if (bus_req) begin
            if (s_cnt >= addr_wait) begin
               bus_addr_ok = 1'b1;
               s_cnt = 0;
               if (data_wait == 0) bus_data_ok = 1'b1;
               else                s_phase = 1'b1;
            end else begin
               s_cnt++;
            end
         end
      end else begin
         s_cnt++;
         if (s_cnt >= data_wait) begin
            bus_data_ok = 1'b1;
            s_phase = 1'b0;
            s_cnt = 0;
         end
      end
   end

   // ---------------- reference model + compare ----------------
   bit          m_busy, m_own, m_acc, m_wr, m_disc;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata, m_ih, m_dh;
   int          m_streak;

   logic [31:0] addr_log[$];
   int          irv_cnt = 0, drv_cnt = 0, breq_cycles = 0, cyc = 0, last_drv_cyc = 0;
   logic [31:0] last_ird = 32'h0, last_drd = 32'h0;
   bit          prev_breq = 1'b0;

   always @(negedge clk) begin
      bit comp, e_req, e_irv, e_drv, e_sif, e_smem, give_data;
      logic [31:0] e_ird, e_drd;
      cyc++;
      if (!rst) begin
         chk("rst_bus_zero", {63'h0, |{bus_req, bus_wr, bus_size, bus_addr, bus_wdata}}, 64'h0);
         chk("rst_resp_zero", {63'h0, |{inst_rvalid, inst_rdata, data_rvalid, data_rdata,
                                        stallreq_if, stallreq_mem}}, 64'h0);
         m_busy = 0; m_own = 0; m_acc = 0; m_wr = 0; m_disc = 0;
         m_size = 2'd0; m_addr = 32'h0; m_wdata = 32'h0; m_ih = 32'h0; m_dh = 32'h0;
         m_streak = 0;
         prev_breq = 1'b0;
      end else begin
         comp   = m_busy && ((!m_acc && bus_addr_ok && bus_data_ok) || (m_acc && bus_data_ok));
         e_req  = m_busy && !m_acc;
         e_irv  = comp && !m_own && !m_disc && !flush;
         e_drv  = comp && m_own;
         e_ird  = e_irv ? bus_rdata : m_ih;
         e_drd  = e_drv ? (m_wr ? 32'h0 : bus_rdata) : m_dh;
         e_smem = data_req && !(comp && m_own);
         e_sif  = (inst_req && !(comp && !m_own)) || data_req;

         chk("bus_req", {63'h0, bus_req}, {63'h0, e_req});
         if (e_req) begin
            chk("bus_wr", {63'h0, bus_wr}, {63'h0, m_wr});
            chk("bus_size", {62'h0, bus_size}, {62'h0, m_size});
            chk("bus_addr", {32'h0, bus_addr}, {32'h0, m_addr});
            if (m_wr) chk("bus_wdata", {32'h0, bus_wdata}, {32'h0, m_wdata});
         end
         chk("inst_rvalid", {63'h0, inst_rvalid}, {63'h0, e_irv});
         chk("inst_rdata", {32'h0, inst_rdata}, {32'h0, e_ird});
         chk("data_rvalid", {63'h0, data_rvalid}, {63'h0, e_drv});
         chk("data_rdata", {32'h0, data_rdata}, {32'h0, e_drd});
         chk("stallreq_if", {63'h0, stallreq_if}, {63'h0, e_sif});
         chk("stallreq_mem", {63'h0, stallreq_mem}, {63'h0, e_smem});

         // observation log for the literal scenario checks
         if (bus_req && !prev_breq) addr_log.push_back(bus_addr);
         prev_breq = bus_req;
         if (bus_req) breq_cycles++;
         if (inst_rvalid) begin irv_cnt++; last_ird = inst_rdata; end
         if (data_rvalid) begin drv_cnt++; last_drd = data_rdata; last_drv_cyc = cyc; end

         // advance the model to the next cycle
         if (comp) begin
            if (e_irv) m_ih = bus_rdata;
            if (e_drv) m_dh = e_drd;
            m_busy = 0; m_disc = 0;
         end else if (m_busy) begin
            if (!m_acc && bus_addr_ok) m_acc = 1;
            if (flush && !m_own) m_disc = 1;
         end else if (!flush && (inst_req || data_req)) begin
            give_data = data_req && !(GUARD && m_streak == MAXS && inst_req);
            m_busy = 1; m_acc = 0; m_disc = 0; m_own = give_data;
            if (give_data) begin
               m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
               if (inst_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : m_streak;
               else          m_streak = 0;
            end else begin
               m_wr = 0; m_size = 2'd2; m_addr = inst_addr; m_wdata = 32'h0;
               m_streak = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_irv(input int start, input string name);
      int k = 0;
      while (irv_cnt == start && k < 40) begin step(); k++; end
      chk(name, 64'(irv_cnt - start), 64'd1);
   endtask

   task automatic wait_drv(input int start, input string name);
      int k = 0;
      while (drv_cnt == start && k < 40) begin step(); k++; end
      chk(name, 64'(drv_cnt - start), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ci, cd, n, bc, c0;
      logic [31:0] exp6;
      rst = 1'b0; flush = 1'b0;
      inst_req = 1'b0; inst_addr = 32'h0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      repeat (3) step();
      chk("reset_bus_req", {63'h0, bus_req}, 64'h0);
      chk("reset_stallreq_if", {63'h0, stallreq_if}, 64'h0);
      rst = 1'b1;
      repeat (2) step();

      // 1: single fetch, addr_ok at once, data_ok two cycles later
      addr_wait = 0; data_wait = 2; slave_rdata = 32'h2408_0001;
      ci = irv_cnt; n = addr_log.size();
      inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
      wait_irv(ci, "t1_inst_rvalid_count");
      inst_req = 1'b0;
      chk("t1_inst_rdata", {32'h0, last_ird}, 64'h2408_0001);
      chk("t1_bus_addr", {32'h0, addr_log[n]}, 64'hBFC0_0000);
      @(negedge clk);
      chk("t1_stallreq_if_low", {63'h0, stallreq_if}, 64'h0);
      chk("t1_inst_rdata_held", {32'h0, inst_rdata}, 64'h2408_0001);
      step();

      // 1b: zero-wait load takes 3 cycles; same-cycle addr_ok/data_ok takes 2
      addr_wait = 0; data_wait = 1; slave_rdata = 32'h0000_1234;
      cd = drv_cnt; c0 = cyc;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0040;
      wait_drv(cd, "t1b_zero_wait_done");
      data_req = 1'b0;
      chk("t1b_zero_wait_latency", 64'(last_drv_cyc - c0), 64'd3);
      step();
      data_wait = 0; slave_rdata = 32'h0000_5678;
      cd = drv_cnt; c0 = cyc;
      data_req = 1'b1; data_addr = 32'h8000_0044;
      wait_drv(cd, "t1b_same_cycle_done");
      data_req = 1'b0;
      chk("t1b_same_cycle_latency", 64'(last_drv_cyc - c0), 64'd2);
      chk("t1b_same_cycle_rdata", {32'h0, last_drd}, 64'h0000_5678);
      step();

      // 2: fetch and load in the same cycle, load goes first
      addr_wait = 0; data_wait = 1; slave_rdata = 32'h1111_2222;
      ci = irv_cnt; cd = drv_cnt; n = addr_log.size();
      inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0010;
      wait_drv(cd, "t2_data_rvalid_count");
      data_req = 1'b0;
      chk("t2_inst_not_before_data", 64'(irv_cnt - ci), 64'd0);
      wait_irv(ci, "t2_inst_rvalid_count");
      inst_req = 1'b0;
      chk("t2_first_addr", {32'h0, addr_log[n]}, 64'h8000_0010);
      chk("t2_second_addr", {32'h0, addr_log[n+1]}, 64'hBFC0_0000);
      chk("t2_data_rdata", {32'h0, last_drd}, 64'h1111_2222);
      step();

      // 3: byte store, addr_ok delayed 3 cycles
      addr_wait = 3; data_wait = 1; slave_rdata = 32'h5555_5555;
      cd = drv_cnt; bc = breq_cycles;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
      data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
      wait_drv(cd, "t3_store_ack_count");
      data_req = 1'b0; data_wr = 1'b0;
      chk("t3_addr_phase_cycles", 64'(breq_cycles - bc), 64'd4);
      chk("t3_store_rdata_zero", {32'h0, last_drd}, 64'h0);
      step();

      // 4: flush during DATA of a fetch
      addr_wait = 0; data_wait = 3; slave_rdata = 32'h0BAD_F00D;
      ci = irv_cnt;
      inst_addr = 32'hBFC0_0004; inst_req = 1'b1;
      step(); step();
      flush = 1'b1; inst_req = 1'b0;
      step();
      flush = 1'b0;
      repeat (5) step();
      chk("t4_no_inst_rvalid", 64'(irv_cnt - ci), 64'd0);
      chk("t4_bus_idle", {63'h0, bus_req}, 64'h0);
      // flush in IDLE blocks the grant for that cycle only
      data_wait = 1; slave_rdata = 32'h0000_0077;
      cd = drv_cnt;
      data_req = 1'b1; data_addr = 32'h8000_0008; flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("t4_no_grant_on_flush", {63'h0, bus_req}, 64'h0);
      wait_drv(cd, "t4_next_access_done");
      data_req = 1'b0;
      step();

      // 5: reset asserted in the middle of an address phase
      addr_wait = 5; data_wait = 1;
      cd = drv_cnt;
      data_req = 1'b1; data_addr = 32'h8000_0020;
      step(); step();
      #2 rst = 1'b0;
      #1;
      chk("t5_async_bus_req", {63'h0, bus_req}, 64'h0);
      chk("t5_async_bus_addr", {32'h0, bus_addr}, 64'h0);
      chk("t5_async_stallreq_mem", {63'h0, stallreq_mem}, 64'h0);
      chk("t5_async_stallreq_if", {63'h0, stallreq_if}, 64'h0);
      step();
      data_req = 1'b0;
      step();
      rst = 1'b1;
      repeat (8) step();
      chk("t5_dropped_no_response", 64'(drv_cnt - cd), 64'd0);
      chk("t5_idle_after_release", {63'h0, bus_req}, 64'h0);

      // 6: continuous fetch and load traffic, grant order
      addr_wait = 0; data_wait = 1; slave_rdata = 32'h0000_600D;
      n = addr_log.size();
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0100;
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      for (int k = 0; k < 100 && addr_log.size() < n + 6; k++) step();
      data_req = 1'b0; inst_req = 1'b0;
      repeat (6) step();
      for (int i = 0; i < 6; i++) begin
         exp6 = (GUARD && i == 4) ? 32'hBFC0_0000 : 32'h8000_0100;
         chk($sformatf("t6_grant%0d", i), {32'h0, addr_log[n+i]}, {32'h0, exp6});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
